// File: rtl/storage_load_sequencer_pkg.sv
// storage_load_sequencer_pkg: shared enums and width defaults for the storage load sequencer.
package storage_load_sequencer_pkg;
    localparam int DATA_W_DEF = 48;
    localparam int IDX_W_DEF  = 32;
    localparam int CODE_W_DEF = 12;
    typedef enum logic [1:0] {TGT_CODE, TGT_INPUT, TGT_LABEL, TGT_WEIGHT} target_e;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_LOC_RST, ST_RUN} state_e;
endpackage

// File: rtl/storage_load_sequencer_write_mux.sv
// storage_write_mux: registers one load transfer and one weight update, decoding the target into a one-hot write strobe.
module storage_write_mux
    import storage_load_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  target_e           wr_target,
    input  logic [IDX_W-1:0]  wr_layer,
    input  logic [IDX_W-1:0]  wr_row,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              upd_en,
    input  logic [IDX_W-1:0]  upd_layer,
    input  logic [IDX_W-1:0]  upd_row,
    input  logic [DATA_W-1:0] upd_dc_dw,
    output logic [3:0]        is_write,
    output logic [IDX_W-1:0]  layer_index,
    output logic [IDX_W-1:0]  row_index,
    output logic [DATA_W-1:0] write_data,
    output logic              is_update,
    output logic [IDX_W-1:0]  upd_layer_index,
    output logic [IDX_W-1:0]  upd_row_index,
    output logic [DATA_W-1:0] upd_dc_dw_q
);
    // is_write bit n belongs to target n; index/data registers are shared by all four ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write        <= '0;
            layer_index     <= '0;
            row_index       <= '0;
            write_data      <= '0;
            is_update       <= 1'b0;
            upd_layer_index <= '0;
            upd_row_index   <= '0;
            upd_dc_dw_q     <= '0;
        end else begin
            is_write  <= wr_en ? 4'(4'b1 << wr_target) : 4'b0;
            is_update <= upd_en;
            if (wr_en) begin
                layer_index <= wr_layer;
                row_index   <= wr_row;
                write_data  <= wr_data;
            end
            if (upd_en) begin
                upd_layer_index <= upd_layer;
                upd_row_index   <= upd_row;
                upd_dc_dw_q     <= upd_dc_dw;
            end
        end
    end
endmodule

// File: rtl/storage_load_sequencer.sv
// storage_load_sequencer: accepts load bursts into code/input/label/weight storage, weight updates, and run control.
module storage_load_sequencer
    import storage_load_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_target,
    input  logic [IDX_W-1:0]  cmd_layer,
    input  logic [IDX_W-1:0]  cmd_count,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [DATA_W-1:0] data_word,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [IDX_W-1:0]  upd_layer,
    input  logic [IDX_W-1:0]  upd_row,
    input  logic [DATA_W-1:0] upd_dc_dw,
    input  logic              run_start,
    input  logic              run_stop,
    output logic              busy,
    output logic              code_storage_enable_interface_enable,
    output logic              controller_enable_interface_enable,
    output logic              matrix_storage_locator_reset_interface_reset,
    output logic              code_storage_is_write,
    output logic [IDX_W-1:0]  code_storage_write_line,
    output logic [CODE_W-1:0] code_storage_write_data,
    output logic              input_storage_is_write,
    output logic [IDX_W-1:0]  input_storage_write_layer_index,
    output logic [IDX_W-1:0]  input_storage_write_row_index,
    output logic [DATA_W-1:0] input_storage_write_data,
    output logic              label_storage_is_write,
    output logic [IDX_W-1:0]  label_storage_write_layer_index,
    output logic [IDX_W-1:0]  label_storage_write_row_index,
    output logic [DATA_W-1:0] label_storage_write_data,
    output logic              weight_storage_is_write,
    output logic [IDX_W-1:0]  weight_storage_write_layer_index,
    output logic [IDX_W-1:0]  weight_storage_write_row_index,
    output logic [DATA_W-1:0] weight_storage_write_data,
    output logic              weight_storage_is_update_interface_is_update,
    output logic [DATA_W-1:0] weight_storage_update_weight_interface_dc_dw,
    output logic [IDX_W-1:0]  weight_storage_update_weight_interface_layer_index,
    output logic [IDX_W-1:0]  weight_storage_update_weight_interface_row_index
);
    state_e            state, state_nx;
    target_e           target;
    logic [IDX_W-1:0]  layer, count, row;
    logic              cmd_fire, data_fire, last;
    logic [3:0]        is_write;
    logic [IDX_W-1:0]  wr_layer_q, wr_row_q;
    logic [DATA_W-1:0] wr_data_q;

    assign cmd_ready  = state == ST_IDLE;
    assign upd_ready  = 1'b1;
    // any granted update steals the cycle, so a weight write can never coincide with it
    assign data_ready = state == ST_LOAD && !upd_valid;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign data_fire  = data_valid && data_ready;
    assign last       = row == count - IDX_W'(1);
    assign busy       = state != ST_IDLE;
    assign matrix_storage_locator_reset_interface_reset = state == ST_LOC_RST;
    assign controller_enable_interface_enable           = state == ST_RUN;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    state_nx = cmd_fire ? (cmd_count != '0 ? ST_LOAD : ST_IDLE)
                                            : (run_start ? ST_LOC_RST : ST_IDLE);
            ST_LOAD:    state_nx = data_fire && last ? ST_IDLE : ST_LOAD;
            ST_LOC_RST: state_nx = ST_RUN;
            ST_RUN:     state_nx = run_stop ? ST_IDLE : ST_RUN;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state  <= ST_IDLE;
            target <= TGT_CODE;
            layer  <= '0;
            count  <= '0;
            row    <= '0;
        end else begin
            state <= state_nx;
            if (cmd_fire) begin
                target <= target_e'(cmd_target);
                layer  <= cmd_layer;
                count  <= cmd_count;
                row    <= '0;
            end else if (data_fire) begin
                row <= row + IDX_W'(1);
            end
        end
    end

    storage_write_mux #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_mux (
        .clk             (clk_clk),
        .rst_n           (reset_reset_n),
        .wr_en           (data_fire),
        .wr_target       (target),
        .wr_layer        (layer),
        .wr_row          (row),
        .wr_data         (data_word),
        .upd_en          (upd_valid && upd_ready),
        .upd_layer       (upd_layer),
        .upd_row         (upd_row),
        .upd_dc_dw       (upd_dc_dw),
        .is_write        (is_write),
        .layer_index     (wr_layer_q),
        .row_index       (wr_row_q),
        .write_data      (wr_data_q),
        .is_update       (weight_storage_is_update_interface_is_update),
        .upd_layer_index (weight_storage_update_weight_interface_layer_index),
        .upd_row_index   (weight_storage_update_weight_interface_row_index),
        .upd_dc_dw_q     (weight_storage_update_weight_interface_dc_dw)
    );

    assign code_storage_is_write                = is_write[TGT_CODE];
    assign code_storage_enable_interface_enable = is_write[TGT_CODE];
    assign code_storage_write_line              = wr_row_q;
    assign code_storage_write_data              = wr_data_q[CODE_W-1:0];
    assign input_storage_is_write               = is_write[TGT_INPUT];
    assign input_storage_write_layer_index      = wr_layer_q;
    assign input_storage_write_row_index        = wr_row_q;
    assign input_storage_write_data             = wr_data_q;
    assign label_storage_is_write               = is_write[TGT_LABEL];
    assign label_storage_write_layer_index      = wr_layer_q;
    assign label_storage_write_row_index        = wr_row_q;
    assign label_storage_write_data             = wr_data_q;
    assign weight_storage_is_write              = is_write[TGT_WEIGHT];
    assign weight_storage_write_layer_index     = wr_layer_q;
    assign weight_storage_write_row_index       = wr_row_q;
    assign weight_storage_write_data            = wr_data_q;
endmodule

// File: tb/tb_storage_load_sequencer.sv
// tb_storage_load_sequencer: directed load, update, run and reset vectors with hand-computed expectations.
module tb_storage_load_sequencer;
    localparam int DW = 48, IW = 32, CW = 12;
    logic clk = 0, rst_n = 0;
    logic cmd_valid = 0, data_valid = 0, upd_valid = 0, run_start = 0, run_stop = 0;
    logic [1:0] cmd_target = 0;
    logic [IW-1:0] cmd_layer = 0, cmd_count = 0, upd_layer = 0, upd_row = 0;
    logic [DW-1:0] data_word = 0, upd_dc_dw = 0;
    logic cmd_ready, data_ready, upd_ready, busy, code_en, ctrl_en, loc_rst;
    logic code_wr, input_wr, label_wr, weight_wr, is_upd;
    logic [IW-1:0] code_line, in_layer, in_row, lb_layer, lb_row, wt_layer, wt_row, up_layer, up_row;
    logic [CW-1:0] code_data;
    logic [DW-1:0] in_data, lb_data, wt_data, up_dc;
    int vectors = 0, miscompares = 0;

    storage_load_sequencer dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
        .cmd_layer(cmd_layer), .cmd_count(cmd_count),
        .data_valid(data_valid), .data_ready(data_ready), .data_word(data_word),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_layer(upd_layer),
        .upd_row(upd_row), .upd_dc_dw(upd_dc_dw),
        .run_start(run_start), .run_stop(run_stop), .busy(busy),
        .code_storage_enable_interface_enable(code_en),
        .controller_enable_interface_enable(ctrl_en),
        .matrix_storage_locator_reset_interface_reset(loc_rst),
        .code_storage_is_write(code_wr), .code_storage_write_line(code_line),
        .code_storage_write_data(code_data),
        .input_storage_is_write(input_wr), .input_storage_write_layer_index(in_layer),
        .input_storage_write_row_index(in_row), .input_storage_write_data(in_data),
        .label_storage_is_write(label_wr), .label_storage_write_layer_index(lb_layer),
        .label_storage_write_row_index(lb_row), .label_storage_write_data(lb_data),
        .weight_storage_is_write(weight_wr), .weight_storage_write_layer_index(wt_layer),
        .weight_storage_write_row_index(wt_row), .weight_storage_write_data(wt_data),
        .weight_storage_is_update_interface_is_update(is_upd),
        .weight_storage_update_weight_interface_dc_dw(up_dc),
        .weight_storage_update_weight_interface_layer_index(up_layer),
        .weight_storage_update_weight_interface_row_index(up_row)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // strobes packed as {code, input, label, weight, update}
    function automatic logic [4:0] strobes();
        return {code_wr, input_wr, label_wr, weight_wr, is_upd};
    endfunction

    task automatic issue(input logic [1:0] tgt, input logic [IW-1:0] lay, input logic [IW-1:0] cnt);
        cmd_valid = 1; cmd_target = tgt; cmd_layer = lay; cmd_count = cnt;
        tick();
        cmd_valid = 0;
    endtask

    initial begin
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_data_ready", data_ready, 0);
        check("rst_upd_ready", upd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ctrl", {code_en, ctrl_en, loc_rst}, 0);
        check("rst_strobes", strobes(), 0);
        #20 rst_n = 1;
        tick();

        // input burst: rows 0..2 on layer 2
        issue(2'd1, 32'd2, 32'd3);
        check("in_busy", busy, 1);
        check("in_data_ready", data_ready, 1);
        for (int i = 0; i < 3; i++) begin
            data_valid = 1; data_word = 48'hA0000 + 48'(i);
            tick();
            check("in_strobes", strobes(), 5'b01000);
            check("in_row", in_row, 64'(i));
            check("in_layer", in_layer, 2);
            check("in_data", in_data, 48'hA0000 + 48'(i));
        end
        data_valid = 0;
        check("in_done_busy", busy, 0);
        tick();
        check("in_idle_strobes", strobes(), 0);

        // code burst: line index and truncated data
        issue(2'd0, 32'd9, 32'd2);
        data_valid = 1; data_word = 48'h000000000ABC;
        tick();
        check("code_strobes0", strobes(), 5'b10000);
        check("code_en0", code_en, 1);
        check("code_line0", code_line, 0);
        check("code_data0", code_data, 12'hABC);
        data_word = 48'hFFF000000123;
        tick();
        check("code_line1", code_line, 1);
        check("code_data1", code_data, 12'h123);
        check("code_en1", code_en, 1);
        data_valid = 0;
        tick();
        check("code_en_off", code_en, 0);

        // weight burst, update collides with word 1
        issue(2'd3, 32'd5, 32'd2);
        data_valid = 1; data_word = 48'h111;
        tick();
        check("wt_strobes0", strobes(), 5'b00010);
        check("wt_row0", wt_row, 0);
        data_word = 48'h222; upd_valid = 1; upd_layer = 7; upd_row = 9; upd_dc_dw = 48'h55;
        #1;
        check("wt_data_ready_blocked", data_ready, 0);
        tick();
        upd_valid = 0;
        check("wt_upd_strobes", strobes(), 5'b00001);
        check("wt_upd_fields", {up_dc[15:0], up_layer[7:0], up_row[7:0]}, 32'h0055_0709);
        tick();
        check("wt_strobes1", strobes(), 5'b00010);
        check("wt_fields1", {wt_data[15:0], wt_layer[7:0], wt_row[7:0]}, 32'h0222_0501);
        check("wt_done_busy", busy, 0);
        data_valid = 0;

        // empty burst, then command beats run_start
        issue(2'd1, 32'd1, 32'd0);
        check("empty_busy", busy, 0);
        check("empty_strobes", strobes(), 0);
        cmd_valid = 1; cmd_target = 2'd2; cmd_layer = 4; cmd_count = 1; run_start = 1;
        tick();
        cmd_valid = 0; run_start = 0;
        check("race_busy", busy, 1);
        check("race_loc_rst", loc_rst, 0);
        check("race_data_ready", data_ready, 1);
        data_valid = 1; data_word = 48'hBEEF;
        tick();
        data_valid = 0;
        check("lb_strobes", strobes(), 5'b00100);
        check("lb_fields", {lb_data[15:0], lb_layer[7:0], lb_row[7:0]}, 32'hBEEF_0400);
        check("lb_done_busy", busy, 0);

        // run sequence
        run_start = 1;
        tick();
        run_start = 0;
        check("run_loc_rst", {loc_rst, ctrl_en, busy}, 3'b101);
        tick();
        check("run_enable", {loc_rst, ctrl_en, busy}, 3'b011);
        run_start = 1; cmd_valid = 1;
        #1;
        check("run_readies", {cmd_ready, data_ready}, 0);
        tick();
        run_start = 0; cmd_valid = 0;
        check("run_restart_ignored", {loc_rst, ctrl_en}, 2'b01);
        run_stop = 1;
        tick();
        run_stop = 0;
        check("run_stopped", {ctrl_en, busy}, 0);

        // reset mid-burst
        issue(2'd1, 32'd1, 32'd3);
        data_valid = 1; data_word = 48'h77;
        tick();
        check("mid_first_write", strobes(), 5'b01000);
        data_word = 48'h88;
        #2 rst_n = 0;
        #1;
        check("mid_rst_strobes", strobes(), 0);
        check("mid_rst_hs", {cmd_ready, data_ready, upd_ready, busy}, 4'b1010);
        check("mid_rst_idx", {in_row, in_layer}, 0);
        check("mid_rst_data", in_data, 0);
        #2 rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_write", strobes(), 0);
            check("mid_idle", busy, 0);
        end
        data_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
